// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-entry sequencer.
// Holds FSM states, ALU opcodes and flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } opcode_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_sequencer_if.sv
// Front-panel bus: switches/buttons in, display/LEDs out.
// master = panel side (drives DataIn/Enter/Undo), slave = sequencer.
interface alu_sequencer_if #(
  parameter int N = 8
);
  logic [N-1:0] DataIn;
  logic         Enter;
  logic         Undo;
  logic [N-1:0] ToDisplay;
  logic [3:0]   Flags;
  logic [1:0]   State;

  modport master (
    output DataIn, Enter, Undo,
    input  ToDisplay, Flags, State
  );

  modport slave (
    input  DataIn, Enter, Undo,
    output ToDisplay, Flags, State
  );
endinterface

// File: rtl/alu_core.sv
// Combinational four-function ALU: A, B, OpCode -> Result, Flags.
// Flags = {N, C, Z, V}; C and V are forced to 0 for logic ops.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   OpCode,
  output logic [N-1:0] Result,
  output logic [3:0]   Flags
);

  logic [N:0] sum;
  logic       arith;
  logic       ovf;
  opcode_t    op;

  assign op = opcode_t'(OpCode);

  always_comb begin
    sum   = '0;
    arith = 1'b0;
    ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum   = {1'b0, A} + {1'b0, B};
        arith = 1'b1;
        ovf   = (A[N-1] == B[N-1]) &&
                (sum[N-1] != A[N-1]);
      end
      OP_SUB: begin
        // Carry out set means no borrow.
        sum   = {1'b0, A} + {1'b0, ~B}
              + {{N{1'b0}}, 1'b1};
        arith = 1'b1;
        ovf   = (A[N-1] != B[N-1]) &&
                (sum[N-1] != A[N-1]);
      end
      OP_OR:  sum = {1'b0, A | B};
      OP_AND: sum = {1'b0, A & B};
      default: sum = '0;
    endcase
  end

  assign Result = sum[N-1:0];

  always_comb begin
    Flags         = 4'b0000;
    Flags[FLAG_N] = sum[N-1];
    Flags[FLAG_C] = arith & sum[N];
    Flags[FLAG_Z] = (sum[N-1:0] == '0);
    Flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Operand-entry controller: Enter edges load A, B, opcode, then show.
// Ports: clk, reset (sync, high); bus = alu_sequencer_if.slave.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input logic              clk,
  input logic              reset,
  alu_sequencer_if.slave   bus
);

  state_t       state;
  logic         enter_q;
  logic         undo_q;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [1:0]   op_reg;
  logic [N-1:0] res_reg;
  logic [3:0]   flg_reg;

  logic         enter_edge;
  logic         undo_edge;
  logic [N-1:0] alu_res;
  logic [3:0]   alu_flg;

  assign enter_edge = bus.Enter & ~enter_q;
  assign undo_edge  = bus.Undo  & ~undo_q;

  alu_core #(.N(N)) u_core (
    .A      (a_reg),
    .B      (b_reg),
    .OpCode (bus.DataIn[1:0]),
    .Result (alu_res),
    .Flags  (alu_flg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_A;
      enter_q <= 1'b0;
      undo_q  <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= 2'b00;
      res_reg <= '0;
      flg_reg <= 4'b0000;
    end else begin
      enter_q <= bus.Enter;
      undo_q  <= bus.Undo;
      // Undo takes priority; a coincident Enter is dropped.
      if (undo_edge) begin
        unique case (state)
          WAIT_A:  state <= WAIT_A;
          WAIT_B:  state <= WAIT_A;
          WAIT_OP: state <= WAIT_B;
          SHOW:    state <= WAIT_OP;
          default: state <= WAIT_A;
        endcase
      end else if (enter_edge) begin
        unique case (state)
          WAIT_A: begin
            a_reg <= bus.DataIn;
            state <= WAIT_B;
          end
          WAIT_B: begin
            b_reg <= bus.DataIn;
            state <= WAIT_OP;
          end
          WAIT_OP: begin
            op_reg  <= bus.DataIn[1:0];
            res_reg <= alu_res;
            flg_reg <= alu_flg;
            state   <= SHOW;
          end
          SHOW: begin
            // Chain: result becomes the next operand A.
            a_reg <= res_reg;
            state <= WAIT_B;
          end
          default: state <= WAIT_A;
        endcase
      end
    end
  end

  assign bus.ToDisplay = (state == SHOW) ? res_reg : bus.DataIn;
  assign bus.Flags     = (state == SHOW) ? flg_reg : 4'b0000;
  assign bus.State     = state;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operand-entry controller for the team's N-bit four-function ALU. A single data input port collects operand A, operand B and the opcode on three successive Enter presses, then shows the registered result and flags. Further presses chain the result back in as operand A. It sits between the board's switch/button front end (debounced, synchronised upstream) and the display/LED drivers.

## Interface
- N, 8, operand/result width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- DataIn  in  N  switch value; operand value, or opcode in bits [1:0]
- Enter  in  1  level from debounced button; acted on at rising edge only
- Undo  in  1  level from debounced button; acted on at rising edge only
- ToDisplay  out  N  value for display driver
- Flags  out  4  {N, C, Z, V}; valid only in SHOW
- State  out  2  current FSM state encoding, for LEDs

## Operation
- Edge detect: two 1-bit registers hold the previous samples of Enter and Undo, both reset to 0.
  - enter_edge = Enter & ~enter_q; undo_edge = Undo & ~undo_q.
- Registers: A_reg[N], B_reg[N], Op_reg[2], Res_reg[N], Flg_reg[4]; all reset to 0.
- States, with 2-bit encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3; reset state WAIT_A.
- Transitions on enter_edge:
  - WAIT_A: A_reg←DataIn, go to WAIT_B.
  - WAIT_B: B_reg←DataIn, go to WAIT_OP.
  - WAIT_OP: Op_reg←DataIn[1:0]; Res_reg and Flg_reg ← ALU(A_reg, B_reg, DataIn[1:0]); go to SHOW.
  - SHOW: A_reg←Res_reg, go to WAIT_B (chaining).
- Transitions on undo_edge:
  - WAIT_B→WAIT_A, WAIT_OP→WAIT_B, SHOW→WAIT_OP.
  - WAIT_A stays.
  - No data register is cleared or modified.
- undo_edge and enter_edge in the same cycle: Undo wins; Enter is discarded.
- ALU opcodes: 00 add, 01 subtract (A + ~B + 1), 10 OR, 11 AND.
  - Result is truncated to N bits.
  - N = Result[N-1]; Z = (Result == 0).
  - C = carry out of bit N-1 for 00/01, 0 for logic ops. C=1 on subtract means no borrow.
  - V = signed overflow for 00/01, 0 for logic ops.
- Outputs (registered state, combinational mux):
  - ToDisplay = Res_reg in SHOW, otherwise DataIn (live echo).
  - Flags = Flg_reg in SHOW, otherwise 4'b0000.
  - State = state encoding.

## Timing
- All state and data updates occur at the rising clk edge where the edge condition is sampled true. Outputs reflect the update from the following cycle.
- Enter held high for any number of cycles produces exactly one action. A new action requires Enter to be sampled low for at least one cycle.
- Result latency: Res_reg and Flags are valid in the first cycle after the third Enter edge is sampled.
- ALU path is combinational from A_reg, B_reg and DataIn[1:0]; it must close timing in one clk period.
- reset dominates every other input:
  - On the next edge, state becomes WAIT_A and every register and edge-detect flop becomes 0.
  - In the following cycle, ToDisplay = DataIn, Flags = 0, State = 0.
- Enter already high when reset releases: counts as an edge on the first post-reset cycle, because enter_q resets to 0.

## Structure
- Package alu_pkg holds:
  - enum state_t (WAIT_A, WAIT_B, WAIT_OP, SHOW; 2-bit)
  - enum opcode_t (OP_ADD, OP_SUB, OP_OR, OP_AND)
  - flag index constants FLAG_N=3, FLAG_C=2, FLAG_Z=1, FLAG_V=0
- One sub-module, alu_core: combinational, parameter N, ports A, B, OpCode → Result, Flags.
- FSM, edge detection, registers and output mux live in alu_sequencer.

## Test plan
- N=8. Reset; Enter edges with DataIn = 05, 03, 00 → SHOW; ToDisplay = 08, Flags = 4'b0000, State = 3.
- A=7F, B=01, op=00 → ToDisplay = 80, Flags = 4'b1001 (N, V).
- A=03, B=03, op=01 → ToDisplay = 00, Flags = 4'b0110 (C, Z).
- Chaining:
  - From SHOW with result 08, Enter (DataIn = FF) → State = 1, A_reg = 08.
  - Then B=02, op=11 → ToDisplay = 00, Flags = 4'b0010.
- Edge and priority:
  - Enter held high 10 cycles in WAIT_A → exactly one transition, to State = 1.
  - In WAIT_B, Enter and Undo rise together → State = 0.
  - Undo in WAIT_A → stays 0.
- Reset asserted in WAIT_OP with A=05, B=03 loaded → next cycle State = 0. Re-entering op=00 without reloading operands uses A=B=0 → result 00, Flags = 4'b0010.
